// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned OCC_W     = CNT_W + 1;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Word-align a fetch address by clearing the byte-offset bits.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(PC_STEP - 1);
    endfunction

    // Sequential successor; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry output FIFO for fetched instructions; entry 0 is always the head.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  fetch_entry_t      i_entry,
    input  logic              i_pop,
    output logic [CNT_W-1:0]  o_count,
    output fetch_entry_t      o_head
);

    fetch_entry_t     r_head;
    fetch_entry_t     r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_full;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_full = (r_count == CNT_W'(BUF_DEPTH));

    // Shift-style storage so the head is read straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_head <= i_entry;
                    end else begin
                        r_tail <= i_entry;
                    end
                    if (!w_full) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - CNT_W'(1);
                end
                2'b11: begin
                    if (r_count == CNT_W'(1)) begin
                        r_head <= i_entry;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A push into a full buffer without a pop means the issue gate let one too many reads out.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(i_push && !w_pop && !i_flush && w_full));

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one ROM read per cycle,
// buffers returned words and hands them to decode with their PC.
module rom_fetch_ctrl
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_entry;
    logic              w_pop;
    logic              w_push;
    logic              w_busy;
    logic              w_room;
    logic              w_issue;
    logic [OCC_W-1:0]  w_occ;

    assign w_pop  = (w_count != '0) & inst_ready;
    assign w_busy = r_inflight | (w_count != '0);

    // Slots committed after this cycle; a new read may go out only if one stays free.
    assign w_occ  = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_room = (w_occ < OCC_W'(BUF_DEPTH));

    // The word on rom_out belongs to a read squashed by a redirect this cycle.
    assign w_push  = r_inflight & ~redirect_valid;
    assign w_entry = {rom_out, r_inflight_pc};

    // Fetch-control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: redirect picks RUN or IDLE outright, otherwise follow enable and busy.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = enable ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        w_state_nxt = w_busy ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        w_state_nxt = RUN;
                    end else if (!w_busy) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Issue only when heading into RUN, never in a redirect cycle, and only with buffer room.
    always_comb begin
        w_issue = 1'b0;
        if ((w_state_nxt == RUN) && !redirect_valid && w_room) begin
            w_issue = 1'b1;
        end
    end

    // PC and the single in-flight read tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= align_pc(redirect_pc);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= next_pc(r_pc);
            end
        end
    end

    fetch_buf u_buf (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign rom_address = r_pc;
    assign inst_valid  = (w_count != '0);
    assign inst        = w_head.inst;
    assign inst_pc     = w_head.pc;
    assign busy        = w_busy;

endmodule
